// File: rtl/redmule_pkg.sv
// Shared types and defaults for the RedMulE TCDM arbiter slice.
package redmule_pkg;

  localparam int unsigned ARB_MAX_OUT_DEFAULT = 4;
  localparam int unsigned TCDM_ADDR_W         = 32;
  localparam int unsigned TCDM_DATA_W         = 32;

  typedef struct packed {
    logic [TCDM_ADDR_W-1:0]   add;
    logic                     wen;
    logic [TCDM_DATA_W/8-1:0] be;
    logic [TCDM_DATA_W-1:0]   data;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DATA_W-1:0] r_data;
    logic                   r_valid;
  } tcdm_rsp_t;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// In-order FIFO of requester indices for transactions still awaiting a response.
module redmule_arb_id_fifo #(
  parameter int unsigned IdW    = 1,
  parameter int unsigned MaxOut = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [IdW-1:0] id_i,
  output logic [IdW-1:0] head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned PtrW = $clog2(MaxOut);

  logic [IdW-1:0]  mem_q [MaxOut];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == (PtrW+1)'(MaxOut));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // MaxOut is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM port between NumReq requesters, with in-order response routing.
// Optional stall counters are enabled by defining REDMULE_TCDM_ARB_PERF_EN.
module redmule_tcdm_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned AddrW  = TCDM_ADDR_W,
  parameter int unsigned DataW  = TCDM_DATA_W,
  parameter int unsigned MaxOut = ARB_MAX_OUT_DEFAULT,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                req_i,
  output logic [NumReq-1:0]                gnt_o,
  input  logic [NumReq-1:0][AddrW-1:0]     add_i,
  input  logic [NumReq-1:0]                wen_i,
  input  logic [NumReq-1:0][DataW/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataW-1:0]     data_i,
  output logic [NumReq-1:0][DataW-1:0]     r_data_o,
  output logic [NumReq-1:0]                r_valid_o,
  output logic                             tgt_req_o,
  input  logic                             tgt_gnt_i,
  output logic [AddrW-1:0]                 tgt_add_o,
  output logic                             tgt_wen_o,
  output logic [DataW/8-1:0]               tgt_be_o,
  output logic [DataW-1:0]                 tgt_data_o,
  input  logic [DataW-1:0]                 tgt_r_data_i,
  input  logic                             tgt_r_valid_i,
  output logic                             busy_o
`ifdef REDMULE_TCDM_ARB_PERF_EN
  ,
  input  logic                             clr_cnt_i,
  output logic [NumReq-1:0][31:0]          stall_cnt_o
`endif
);

  logic [IdW-1:0] rr_q, rr_d;
  logic [IdW-1:0] sel, cand, head;
  logic           found;
  logic           handshake, rsp_ok;
  logic           fifo_full, fifo_empty;

  // Search upward from the pointer, wrapping at NumReq (need not be a power of two).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = rr_q;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = (cand == IdW'(NumReq-1)) ? '0 : cand + 1'b1;
    end
  end

  // Requests are ignored while reset is asserted.
  assign tgt_req_o  = rst_ni & (|req_i) & ~fifo_full;
  assign handshake  = tgt_req_o & tgt_gnt_i;
  assign tgt_add_o  = add_i[sel];
  assign tgt_wen_o  = wen_i[sel];
  assign tgt_be_o   = be_i[sel];
  assign tgt_data_o = data_i[sel];

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = handshake;
    rr_d       = rr_q;
    if (handshake) rr_d = (sel == IdW'(NumReq-1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  // A response with nothing outstanding is dropped.
  assign rsp_ok   = tgt_r_valid_i & ~fifo_empty;
  assign r_data_o = {NumReq{tgt_r_data_i}};

  always_comb begin
    r_valid_o       = '0;
    r_valid_o[head] = rsp_ok;
  end

  assign busy_o = ~fifo_empty;

  redmule_arb_id_fifo #(
    .IdW    (IdW),
    .MaxOut (MaxOut)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .pop_i   (rsp_ok),
    .id_i    (sel),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef REDMULE_TCDM_ARB_PERF_EN
  for (genvar gi = 0; gi < int'(NumReq); gi++) begin : g_stall_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                     cnt_q <= '0;
      else if (clr_cnt_i)                              cnt_q <= '0;
      else if (req_i[gi] && !gnt_o[gi] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign stall_cnt_o[gi] = cnt_q;
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(tgt_r_valid_i && fifo_empty))
        else $warning("redmule_tcdm_arbiter: response with no outstanding transaction dropped");
    end
  end
`endif

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed bench for redmule_tcdm_arbiter (NumReq=2, MaxOut=4).
module tb_redmule_tcdm_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0]       gnt_o;
    logic [1:0][31:0] add_i;
    logic [1:0]       wen_i;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] data_i;
    logic [1:0][31:0] r_data_o;
    logic [1:0]       r_valid_o;
    logic             tgt_req_o;
    logic             tgt_gnt_i;
    logic [31:0]      tgt_add_o;
    logic             tgt_wen_o;
    logic [3:0]       tgt_be_o;
    logic [31:0]      tgt_data_o;
    logic [31:0]      tgt_r_data_i;
    logic             tgt_r_valid_i;
    logic             busy_o;
`ifdef REDMULE_TCDM_ARB_PERF_EN
    logic             clr_cnt_i;
    logic [1:0][31:0] stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int n0, n1;
    logic [1:0] exp_g, prev_g;
    logic done = 1'b0;

    always #5 clk_i = ~clk_i;

    redmule_tcdm_arbiter #(.NumReq(2), .AddrW(32), .DataW(32), .MaxOut(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .add_i         (add_i),
        .wen_i         (wen_i),
        .be_i          (be_i),
        .data_i        (data_i),
        .r_data_o      (r_data_o),
        .r_valid_o     (r_valid_o),
        .tgt_req_o     (tgt_req_o),
        .tgt_gnt_i     (tgt_gnt_i),
        .tgt_add_o     (tgt_add_o),
        .tgt_wen_o     (tgt_wen_o),
        .tgt_be_o      (tgt_be_o),
        .tgt_data_o    (tgt_data_o),
        .tgt_r_data_i  (tgt_r_data_i),
        .tgt_r_valid_i (tgt_r_valid_i),
        .busy_o        (busy_o)
`ifdef REDMULE_TCDM_ARB_PERF_EN
        ,
        .clr_cnt_i     (clr_cnt_i),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s: observed=%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i         = 2'b00;
        tgt_gnt_i     = 1'b0;
        tgt_r_valid_i = 1'b0;
        tgt_r_data_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        if (!done) begin
            errors++;
            $error("FAIL timeout: directed sequence did not complete");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        add_i  = '{32'h0000_0200, 32'h1C01_0000};
        wen_i  = 2'b01;
        be_i   = '{4'h3, 4'hF};
        data_i = '{32'h2222_2222, 32'h1111_1111};
`ifdef REDMULE_TCDM_ARB_PERF_EN
        clr_cnt_i = 1'b0;
`endif

        tick();
        req_i = 2'b11; tgt_gnt_i = 1'b1;
        #1;
        chk("rst_tgt_req", tgt_req_o, 1'b0);
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rvalid", r_valid_o, 2'b00);
        tick();
        do_reset();

        req_i = 2'b01; tgt_gnt_i = 1'b1;
        #1;
        chk("single_gnt", gnt_o, 2'b01);
        chk("single_add", tgt_add_o, 32'h1C01_0000);
        chk("single_wen", tgt_wen_o, 1'b1);
        chk("single_busy0", busy_o, 1'b0);
        tick();
        req_i = 2'b00; tgt_gnt_i = 1'b0;
        #1;
        chk("single_gnt_off", gnt_o, 2'b00);
        chk("single_busy1", busy_o, 1'b1);
        chk("single_noresp", r_valid_o, 2'b00);
        tick();
        tgt_r_valid_i = 1'b1; tgt_r_data_i = 32'hDEAD_BEEF;
        #1;
        chk("single_busy2", busy_o, 1'b1);
        chk("single_rvalid", r_valid_o, 2'b01);
        chk("single_rdata0", r_data_o[0], 32'hDEAD_BEEF);
        chk("single_rdata1", r_data_o[1], 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #1;
        chk("single_busy_end", busy_o, 1'b0);
        chk("single_rvalid_end", r_valid_o, 2'b00);

        do_reset();
        n0 = 0; n1 = 0; prev_g = 2'b00;
        for (int k = 0; k < 8; k++) begin
            req_i = 2'b11; tgt_gnt_i = 1'b1; tgt_r_valid_i = (k != 0);
            tgt_r_data_i = 32'h100 + k;
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("fair_gnt", gnt_o, exp_g);
            chk("fair_rvalid", r_valid_o, prev_g);
            if (gnt_o == 2'b01) n0++;
            if (gnt_o == 2'b10) n1++;
            prev_g = exp_g;
            tick();
        end
        req_i = 2'b00; tgt_gnt_i = 1'b0; tgt_r_valid_i = 1'b1;
        #1;
        chk("fair_last_rvalid", r_valid_o, 2'b10);
        chk("fair_count0", n0, 4);
        chk("fair_count1", n1, 4);
        tick();
        idle_inputs();
        #1;
        chk("fair_busy_end", busy_o, 1'b0);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_i = 2'b11; tgt_gnt_i = 1'b1;
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("bp_gnt", gnt_o, exp_g);
            tick();
        end
        #1;
        chk("bp_full_req", tgt_req_o, 1'b0);
        chk("bp_full_gnt", gnt_o, 2'b00);
        chk("bp_full_busy", busy_o, 1'b1);
        tick();
        tgt_r_valid_i = 1'b1; tgt_r_data_i = 32'h11;
        #1;
        chk("bp_pop_rvalid", r_valid_o, 2'b01);
        chk("bp_pop_same_req", tgt_req_o, 1'b0);
        chk("bp_pop_same_gnt", gnt_o, 2'b00);
        tick();
        tgt_r_valid_i = 1'b0;
        #1;
        chk("bp_resume_req", tgt_req_o, 1'b1);
        chk("bp_resume_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b00; tgt_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tgt_r_valid_i = 1'b1;
            #1;
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            chk("bp_drain_rvalid", r_valid_o, exp_g);
            tick();
        end
        tgt_r_valid_i = 1'b0;
        #1;
        chk("bp_busy_end", busy_o, 1'b0);

        do_reset();
        tgt_gnt_i = 1'b1;
        req_i = 2'b10;
        #1;
        chk("ord_gnt1", gnt_o, 2'b10);
        chk("ord_add1", tgt_add_o, 32'h0000_0200);
        chk("ord_wen1", tgt_wen_o, 1'b0);
        chk("ord_be1", tgt_be_o, 4'h3);
        chk("ord_data1", tgt_data_o, 32'h2222_2222);
        tick();
        req_i = 2'b01;
        #1;
        chk("ord_gnt0", gnt_o, 2'b01);
        chk("ord_data0", tgt_data_o, 32'h1111_1111);
        tick();
        req_i = 2'b10;
        #1;
        chk("ord_gnt1b", gnt_o, 2'b10);
        tick();
        req_i = 2'b00; tgt_gnt_i = 1'b0;
        tgt_r_valid_i = 1'b1; tgt_r_data_i = 32'hA;
        #1;
        chk("ord_rv_a", r_valid_o, 2'b10);
        chk("ord_rd_a", r_data_o[1], 32'hA);
        tick();
        tgt_r_data_i = 32'hB;
        #1;
        chk("ord_rv_b", r_valid_o, 2'b01);
        chk("ord_rd_b", r_data_o[0], 32'hB);
        tick();
        tgt_r_data_i = 32'hC;
        #1;
        chk("ord_rv_c", r_valid_o, 2'b10);
        chk("ord_rd_c", r_data_o[1], 32'hC);
        tick();
        idle_inputs();
        #1;
        chk("ord_busy_end", busy_o, 1'b0);

        do_reset();
        req_i = 2'b01; tgt_gnt_i = 1'b1;
        tick();
        req_i = 2'b00; tgt_gnt_i = 1'b0; tgt_r_valid_i = 1'b1;
        tick();
        tgt_r_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_i = 2'b11;
            #1;
            chk("stall_gnt", gnt_o, 2'b00);
            chk("stall_req", tgt_req_o, 1'b1);
            chk("stall_sel_add", tgt_add_o, 32'h0000_0200);
            tick();
        end
`ifdef REDMULE_TCDM_ARB_PERF_EN
        chk("perf_stall1", stall_cnt_o[1], 32'd5);
        chk("perf_stall0", stall_cnt_o[0], 32'd5);
`endif
        tgt_gnt_i = 1'b1;
        #1;
        chk("stall_first_gnt", gnt_o, 2'b10);
        tick();
        req_i = 2'b00; tgt_gnt_i = 1'b0; tgt_r_valid_i = 1'b1;
        #1;
        chk("stall_rvalid", r_valid_o, 2'b10);
        tick();
        idle_inputs();

        req_i = 2'b11; tgt_gnt_i = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("rst3_busy_before", busy_o, 1'b1);
        do_reset();
        chk("rst3_busy_after", busy_o, 1'b0);
`ifdef REDMULE_TCDM_ARB_PERF_EN
        chk("rst3_perf0", stall_cnt_o[0], 32'd0);
        chk("rst3_perf1", stall_cnt_o[1], 32'd0);
`endif
        tgt_r_valid_i = 1'b1; tgt_r_data_i = 32'h5555_AAAA;
        #1;
        chk("stray_rvalid", r_valid_o, 2'b00);
        tick();
        tgt_r_valid_i = 1'b0;
        #1;
        chk("stray_busy", busy_o, 1'b0);
        chk("stray_rvalid_after", r_valid_o, 2'b00);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
